// File: rtl/zxuno_regwin_pkg.sv
// Shared constants and types for the zxuno_regwin I/O register window.
// Holds the default port addresses and the control-register bit layout.
package zxuno_regwin_pkg;

  localparam logic [15:0] IoAddrDefault = 16'hFC3B;
  localparam logic [15:0] IoDataDefault = 16'hFD3B;

  // Control register: bit 0 = auto-increment on data write, bit 1 = on data read
  localparam int unsigned CtrlAincWr = 0;
  localparam int unsigned CtrlAincRd = 1;
  localparam logic [7:0]  CtrlMask   = 8'h03;

  typedef enum logic [1:0] {
    RdNone,
    RdAddr,
    RdCtrl,
    RdReg
  } rd_sel_e;

  function automatic logic io_match(input logic [15:0] addr, input logic [15:0] port,
                                    input logic iorq_n, input logic strobe_n);
    return !iorq_n && !strobe_n && (addr == port);
  endfunction

endpackage

// File: rtl/zxuno_regwin_io_cycle_edge.sv
// Turns a multi-clock bus-cycle level into single-clock rise/fall pulses.
// History resets to 1 so a cycle already in progress at reset never pulses.
module zxuno_regwin_io_cycle_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic rise_o,
  output logic fall_o
);

  logic hist_q;
  logic armed_q, armed_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= level_i;
      armed_q <= armed_d;
    end
  end

  // A fall only counts for a cycle whose rise was seen, so a cycle truncated
  // by reset (or the idle bus right after reset) cannot produce a fall pulse.
  always_comb begin
    rise_o  = level_i & ~hist_q & ~rst_i;
    fall_o  = hist_q & ~level_i & armed_q & ~rst_i;
    armed_d = armed_q;
    if (rise_o) begin
      armed_d = 1'b1;
    end else if (fall_o) begin
      armed_d = 1'b0;
    end
  end

endmodule

// File: rtl/zxuno_regwin.sv
// I/O-mapped register window: address port selects a core register, data port
// accesses it, with an in-window control register for address auto-increment.
module zxuno_regwin
  import zxuno_regwin_pkg::*;
#(
  parameter logic [15:0]   IOADDR    = IoAddrDefault,
  parameter logic [15:0]   IODATA    = IoDataDefault,
  parameter int unsigned   AW        = 8,
  parameter logic [AW-1:0] CTRL_ADDR = {AW{1'b1}}
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [15:0]   a_i,
  input  logic          iorq_n_i,
  input  logic          rd_n_i,
  input  logic          wr_n_i,
  input  logic [7:0]    din_i,
  input  logic [7:0]    reg_din_i,
  output logic [7:0]    dout_o,
  output logic          oe_n_o,
  output logic [AW-1:0] addr_o,
  output logic          read_from_reg_o,
  output logic          read_done_o,
  output logic          write_to_reg_o,
  output logic          regaddr_changed_o
);

  logic aw, ar, dw, dr;
  logic aw_rise, wpulse, rend;
  logic aw_fall_unused, dw_fall_unused, dr_rise_unused;
  logic hit_ctrl, do_inc;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [7:0]    ctrl_q, ctrl_d;
  rd_sel_e       rd_sel;

  always_comb begin
    aw = io_match(a_i, IOADDR, iorq_n_i, wr_n_i);
    ar = io_match(a_i, IOADDR, iorq_n_i, rd_n_i);
    dw = io_match(a_i, IODATA, iorq_n_i, wr_n_i);
    dr = io_match(a_i, IODATA, iorq_n_i, rd_n_i);
  end

  zxuno_regwin_io_cycle_edge u_aw_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .level_i (aw),
    .rise_o  (aw_rise),
    .fall_o  (aw_fall_unused)
  );

  zxuno_regwin_io_cycle_edge u_dw_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .level_i (dw),
    .rise_o  (wpulse),
    .fall_o  (dw_fall_unused)
  );

  zxuno_regwin_io_cycle_edge u_dr_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .level_i (dr),
    .rise_o  (dr_rise_unused),
    .fall_o  (rend)
  );

  always_comb begin
    hit_ctrl          = (raddr_q == CTRL_ADDR);
    regaddr_changed_o = aw_rise;
    write_to_reg_o    = wpulse & ~hit_ctrl;
    read_done_o       = rend & ~hit_ctrl;
    read_from_reg_o   = dr & ~hit_ctrl;
    addr_o            = raddr_q;
  end

  // Address-port write beats increment; write and read increments share one +1.
  always_comb begin
    raddr_d = raddr_q;
    ctrl_d  = ctrl_q;
    do_inc  = (write_to_reg_o & ctrl_q[CtrlAincWr]) | (read_done_o & ctrl_q[CtrlAincRd]);
    if (aw_rise) begin
      raddr_d = din_i[AW-1:0];
    end else if (do_inc) begin
      raddr_d = raddr_q + AW'(1);
    end
    if (wpulse && hit_ctrl) begin
      ctrl_d = din_i & CtrlMask;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raddr_q <= '0;
      ctrl_q  <= 8'h00;
    end else begin
      raddr_q <= raddr_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    if (ar) begin
      rd_sel = RdAddr;
    end else if (dr) begin
      rd_sel = hit_ctrl ? RdCtrl : RdReg;
    end else begin
      rd_sel = RdNone;
    end
  end

  always_comb begin
    dout_o = 8'h00;
    oe_n_o = 1'b0;
    unique case (rd_sel)
      RdAddr:  dout_o = 8'(raddr_q);
      RdCtrl:  dout_o = ctrl_q;
      RdReg:   dout_o = reg_din_i;
      default: oe_n_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_zxuno_regwin.sv
// Scoreboard bench: two windows (AW=8 default, AW=4 with control at index 6)
// share one CPU bus; a transaction-level model predicts every strobe and read.
module tb_zxuno_regwin;

  localparam logic [15:0] PortAddr = 16'hFC3B;
  localparam logic [15:0] PortData = 16'hFD3B;

  typedef enum int {EvAddr, EvWrite, EvRead, EvDone} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int unsigned addr;
    int unsigned data;
    bit          rfr;
  } ev_t;

  logic        clk, rst;
  logic [15:0] a;
  logic        iorq_n, rd_n, wr_n;
  logic [7:0]  din, reg_din;

  logic [7:0] dout8, dout4;
  logic       oe8, oe4, rfr8, rfr4, rdone8, rdone4, wtr8, wtr4, rac8, rac4;
  logic [7:0] addr8;
  logic [3:0] addr4;

  logic [7:0] addr_w[2], dout_w[2];
  logic       oe_w[2], rfr_w[2], rdone_w[2], wtr_w[2], rac_w[2];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int unsigned m_addr[2];
  int unsigned m_ctrl[2];
  ev_t sb0[$];
  ev_t sb1[$];
  bit  prev_oe[2] = '{1'b1, 1'b1};

  zxuno_regwin u_dut8 (
    .clk_i             (clk),
    .rst_i             (rst),
    .a_i               (a),
    .iorq_n_i          (iorq_n),
    .rd_n_i            (rd_n),
    .wr_n_i            (wr_n),
    .din_i             (din),
    .reg_din_i         (reg_din),
    .dout_o            (dout8),
    .oe_n_o            (oe8),
    .addr_o            (addr8),
    .read_from_reg_o   (rfr8),
    .read_done_o       (rdone8),
    .write_to_reg_o    (wtr8),
    .regaddr_changed_o (rac8)
  );

  zxuno_regwin #(
    .AW        (4),
    .CTRL_ADDR (4'h6)
  ) u_dut4 (
    .clk_i             (clk),
    .rst_i             (rst),
    .a_i               (a),
    .iorq_n_i          (iorq_n),
    .rd_n_i            (rd_n),
    .wr_n_i            (wr_n),
    .din_i             (din),
    .reg_din_i         (reg_din),
    .dout_o            (dout4),
    .oe_n_o            (oe4),
    .addr_o            (addr4),
    .read_from_reg_o   (rfr4),
    .read_done_o       (rdone4),
    .write_to_reg_o    (wtr4),
    .regaddr_changed_o (rac4)
  );

  assign addr_w[0]  = addr8;
  assign addr_w[1]  = {4'h0, addr4};
  assign dout_w[0]  = dout8;
  assign dout_w[1]  = dout4;
  assign oe_w[0]    = oe8;
  assign oe_w[1]    = oe4;
  assign rfr_w[0]   = rfr8;
  assign rfr_w[1]   = rfr4;
  assign rdone_w[0] = rdone8;
  assign rdone_w[1] = rdone4;
  assign wtr_w[0]   = wtr8;
  assign wtr_w[1]   = wtr4;
  assign rac_w[0]   = rac8;
  assign rac_w[1]   = rac4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned size_of(input int d);
    return (d == 0) ? 256 : 16;
  endfunction

  function automatic int unsigned ctrl_of(input int d);
    return (d == 0) ? 255 : 6;
  endfunction

  function automatic ev_t mk(input ev_kind_e k, input int unsigned ad, input int unsigned da,
                             input bit rf);
    ev_t e;
    e.kind = k;
    e.addr = ad;
    e.data = da;
    e.rfr  = rf;
    return e;
  endfunction

  function automatic void push(input int d, input ev_t e);
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endfunction

  function automatic void model_out(input logic [15:0] port, input int unsigned data);
    for (int d = 0; d < 2; d++) begin
      if (port == PortAddr) begin
        push(d, mk(EvAddr, 0, 0, 1'b0));
        m_addr[d] = data % size_of(d);
      end else if (port == PortData) begin
        if (m_addr[d] == ctrl_of(d)) begin
          m_ctrl[d] = data & 3;
        end else begin
          push(d, mk(EvWrite, m_addr[d], data, 1'b0));
          if ((m_ctrl[d] & 1) != 0) m_addr[d] = (m_addr[d] + 1) % size_of(d);
        end
      end
    end
  endfunction

  function automatic void model_in(input logic [15:0] port, input int unsigned rdata);
    for (int d = 0; d < 2; d++) begin
      if (port == PortAddr) begin
        push(d, mk(EvRead, 0, m_addr[d], 1'b0));
      end else if (port == PortData) begin
        if (m_addr[d] == ctrl_of(d)) begin
          push(d, mk(EvRead, 0, m_ctrl[d], 1'b0));
        end else begin
          push(d, mk(EvRead, 0, rdata, 1'b1));
          push(d, mk(EvDone, m_addr[d], 0, 1'b0));
          if ((m_ctrl[d] & 2) != 0) m_addr[d] = (m_addr[d] + 1) % size_of(d);
        end
      end
    end
  endfunction

  // ---------------- stimulus ----------------
  task automatic io_cycle(input bit is_wr, input logic [15:0] port, input logic [7:0] data,
                          input int hold, input int gap);
    if (is_wr) begin
      model_out(port, data);
      din  = data;
      wr_n = 1'b0;
    end else begin
      model_in(port, data);
      reg_din = data;
      rd_n    = 1'b0;
    end
    a      = port;
    iorq_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    rd_n   = 1'b1;
    a      = 16'h0000;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic sync_check_addr(input string tag);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("dut%0d addr %s", d, tag), addr_w[d], m_addr[d]);
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string tag);
    check($sformatf("dut0 pending events %s", tag), sb0.size(), 0);
    check($sformatf("dut1 pending events %s", tag), sb1.size(), 0);
  endtask

  // ---------------- monitor ----------------
  task automatic pop_ev(input int d, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = mk(EvAddr, 0, 0, 1'b0);
    if (d == 0 && sb0.size() > 0) begin
      e  = sb0.pop_front();
      ok = 1'b1;
    end else if (d == 1 && sb1.size() > 0) begin
      e  = sb1.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic expect_ev(input int d, input string what, input ev_kind_e k, output ev_t e,
                           output bit ok);
    pop_ev(d, e, ok);
    if (!ok) begin
      n_checks++;
      $display("FAIL dut%0d %s: got unexpected event at %0t, expected none", d, what, $time);
    end else begin
      check($sformatf("dut%0d %s kind", d, what), e.kind, k);
    end
  endtask

  task automatic monitor_one(input int d);
    ev_t e;
    bit  ok;
    if (rac_w[d]) expect_ev(d, "regaddr_changed", EvAddr, e, ok);
    if (wtr_w[d]) begin
      expect_ev(d, "write_to_reg", EvWrite, e, ok);
      if (ok) begin
        check($sformatf("dut%0d write addr", d), addr_w[d], e.addr);
        check($sformatf("dut%0d write din", d), din, e.data);
      end
    end
    if (!oe_w[d] && prev_oe[d]) begin
      expect_ev(d, "read start", EvRead, e, ok);
      if (ok) begin
        check($sformatf("dut%0d read dout", d), dout_w[d], e.data);
        check($sformatf("dut%0d read_from_reg", d), rfr_w[d], e.rfr);
      end
    end
    if (rdone_w[d]) begin
      expect_ev(d, "read_done", EvDone, e, ok);
      if (ok) check($sformatf("dut%0d read_done addr", d), addr_w[d], e.addr);
    end
    if (oe_w[d]) check($sformatf("dut%0d idle dout", d), dout_w[d], 0);
    prev_oe[d] = oe_w[d];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) monitor_one(d);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] other_ports[4];
    int          r;
    other_ports = '{16'hFC3A, 16'h003B, 16'hFD3C, 16'h7C3B};
    rst = 1'b1; a = 16'h0; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    din = 8'h00; reg_din = 8'h00;
    m_addr = '{0, 0};
    m_ctrl = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset addr", d), addr_w[d], 0);
      check($sformatf("dut%0d reset oe_n", d), oe_w[d], 1);
      check($sformatf("dut%0d reset strobes", d),
            {rac_w[d], wtr_w[d], rdone_w[d], rfr_w[d]}, 0);
    end
    @(posedge clk);
    #1;

    // Directed scenarios
    io_cycle(1'b1, PortAddr, 8'h05, 4, 2);
    sync_check_addr("after addr write");
    io_cycle(1'b0, PortAddr, 8'h00, 2, 1);
    io_cycle(1'b1, PortData, 8'hA5, 3, 1);
    sync_check_addr("after plain write");
    io_cycle(1'b1, PortAddr, 8'hFF, 2, 1);
    io_cycle(1'b1, PortData, 8'h01, 1, 1);
    io_cycle(1'b1, PortAddr, 8'hFD, 1, 1);
    io_cycle(1'b1, PortData, 8'h11, 2, 1);
    io_cycle(1'b1, PortData, 8'h22, 1, 2);
    io_cycle(1'b1, PortData, 8'h33, 3, 1);
    sync_check_addr("after write block");
    io_cycle(1'b1, PortAddr, 8'hFF, 1, 1);
    io_cycle(1'b1, PortData, 8'h02, 1, 1);
    io_cycle(1'b1, PortAddr, 8'h10, 1, 1);
    io_cycle(1'b0, PortData, 8'h5A, 3, 1);
    sync_check_addr("after read inc");
    io_cycle(1'b1, PortAddr, 8'hF6, 1, 1);
    io_cycle(1'b1, PortData, 8'h03, 1, 1);
    io_cycle(1'b1, PortAddr, 8'hFF, 1, 1);
    io_cycle(1'b1, PortData, 8'h03, 2, 1);
    io_cycle(1'b0, PortData, 8'hC3, 1, 1);
    sync_check_addr("after wrap");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int hold, gap;
      hold = $urandom_range(1, 4);
      gap  = $urandom_range(1, 2);
      r    = $urandom_range(0, 99);
      if (r < 20) begin
        logic [7:0] ad;
        case ($urandom_range(0, 3))
          0:       ad = 8'hFF;
          1:       ad = 8'hF6;
          default: ad = 8'($urandom);
        endcase
        io_cycle(1'b1, PortAddr, ad, hold, gap);
      end else if (r < 50) begin
        io_cycle(1'b1, PortData, 8'($urandom), hold, gap);
      end else if (r < 75) begin
        io_cycle(1'b0, PortData, 8'($urandom), hold, gap);
      end else if (r < 85) begin
        io_cycle(1'b0, PortAddr, 8'($urandom), hold, gap);
      end else begin
        io_cycle(1'($urandom), other_ports[$urandom_range(0, 3)], 8'($urandom), hold, gap);
      end
    end
    sync_check_addr("after random");
    check_drained("after random");

    // Reset arriving during a data write that is still held afterwards
    io_cycle(1'b1, PortAddr, 8'h20, 1, 1);
    check_drained("before reset");
    m_addr = '{0, 0};
    m_ctrl = '{0, 0};
    a = PortData; din = 8'h77; iorq_n = 1'b0; wr_n = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    iorq_n = 1'b1; wr_n = 1'b1; a = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    sync_check_addr("after mid-write reset");
    io_cycle(1'b1, PortAddr, 8'hFF, 1, 1);
    io_cycle(1'b0, PortData, 8'h9C, 2, 2);
    check_drained("at end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
